main_sequencer: RTL and testbench

- Parametrised top-level sequencer for the NASTI DDRx controller. It brings up the DFI PHY and then the DRAM, and runs per-rank calibration.
- In operation it arbitrates the shared DFI bus among the init engine, the calibration engine and the transaction engine via `sel`.
- Adds what the single-rank controller lacked: multi-rank calibration, periodic DFI controller-update, a proper PHY-update handshake that drains traffic first, and a retry/error path.

---
 rtl/main_seq_pkg.sv | 41 ++++
 rtl/main_sequencer_upd_timer.sv | 28 ++
 rtl/main_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_main_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_seq_pkg.sv
// Shared types and encodings for the DDRx main sequencer and its helpers.
package main_seq_pkg;

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_INIT_DFI = 4'd1,
        ST_INIT_DDR = 4'd2,
        ST_CALI     = 4'd3,
        ST_IDLE     = 4'd4,
        ST_DRAIN    = 4'd5,
        ST_PHYUPD   = 4'd6,
        ST_CTRLUPD  = 4'd7,
        ST_ERROR    = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        TGT_PHYUPD  = 2'd0,
        TGT_CALI    = 2'd1,
        TGT_CTRLUPD = 2'd2
    } drain_tgt_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_INIT = 2'b01;
    localparam logic [1:0] SEL_CALI = 2'b10;
    localparam logic [1:0] SEL_TRAN = 2'b11;

    localparam logic [1:0] DFI_FREQ_RATIO_1TO4 = 2'b11;

    // DFI bus owner for each state; the transaction engine keeps the bus while draining.
    function automatic logic [1:0] sel_for(input state_t s);
        logic [1:0] sel;
        case (s)
            ST_INIT_DDR:        sel = SEL_INIT;
            ST_CALI:            sel = SEL_CALI;
            ST_IDLE, ST_DRAIN:  sel = SEL_TRAN;
            default:            sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/main_sequencer_upd_timer.sv
// Saturating interval counter that paces controller-initiated DFI updates.
module upd_timer #(
    parameter int INTERVAL = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (INTERVAL > 0) ? $clog2(INTERVAL + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(INTERVAL);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    // An interval of zero leaves the counter parked at zero and never fires.
    assign expired = (INTERVAL != 0) && (count == LIMIT);

endmodule

// File: rtl/main_sequencer.sv
// DFI/DRAM bring-up, per-rank calibration with retries, and DFI bus arbitration.
// Define MAIN_SEQ_WATCHDOG_EN to add a per-state timeout that forces ERROR.
module main_sequencer
    import main_seq_pkg::*;
#(
    parameter int NUM_RANKS        = 1,
    parameter int NUM_BYTES        = 8,
    parameter int CTRLUPD_INTERVAL = 4096,
    parameter int CALI_RETRIES     = 2,
    parameter int TIMEOUT_CYCLES   = 65536
) (
    input  logic                         core_clk,
    input  logic                         core_arstn,
    input  logic                         r_empty,
    output logic                         ddr_init_start,
    input  logic                         ddr_init_done,
    output logic                         cali_start,
    output logic [$clog2(NUM_RANKS):0]   cali_rank,
    input  logic                         cali_done,
    input  logic                         cali_fail,
    output logic                         tran_start,
    input  logic                         tran_done,
    output logic [1:0]                   sel,
    output logic                         dfi_init_start,
    input  logic                         dfi_init_complete,
    output logic [1:0]                   dfi_freq_ratio,
    output logic [NUM_BYTES-1:0]         dfi_data_byte_disable,
    output logic [NUM_RANKS-1:0]         dfi_dram_clk_disable,
    output logic                         dfi_ctrlupd_req,
    input  logic                         dfi_ctrlupd_ack,
    input  logic                         dfi_phyupd_req,
    output logic                         dfi_phyupd_ack,
    input  logic                         dfi_rdlvl_req,
    input  logic                         dfi_wrlvl_req,
    output logic                         err,
    output logic [3:0]                   state_o
);

    localparam int RKW = $clog2(NUM_RANKS) + 1;
    localparam int RTW = (CALI_RETRIES > 0) ? $clog2(CALI_RETRIES + 1) : 1;
    localparam logic [RKW-1:0] LAST_RANK = RKW'(NUM_RANKS - 1);
    localparam logic [RTW-1:0] RETRY_MAX = RTW'(CALI_RETRIES);

    state_t         state, next_state;
    drain_tgt_t     tgt, next_tgt;
    logic [RKW-1:0] rank, next_rank;
    logic [RTW-1:0] retry, next_retry;
    logic           cali_pulse;
    logic           ack_seen, upd_held;
    logic           timer_clear, timer_en, timer_expired;
    logic           wd_hit;

    assign timer_en    = (state == ST_IDLE) || (state == ST_DRAIN);
    assign timer_clear = ((state == ST_CTRLUPD) && (next_state != ST_CTRLUPD)) ||
                         ((state == ST_CALI) && (next_state == ST_IDLE));

    upd_timer #(.INTERVAL(CTRLUPD_INTERVAL)) u_upd_timer (
        .clk     (core_clk),
        .rst_n   (core_arstn),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        next_state = state;
        next_tgt   = tgt;
        next_rank  = rank;
        next_retry = retry;
        cali_pulse = 1'b0;
        case (state)
            ST_RESET:    next_state = ST_INIT_DFI;
            ST_INIT_DFI: if (dfi_init_complete) next_state = ST_INIT_DDR;
            ST_INIT_DDR: begin
                if (ddr_init_done) begin
                    next_state = ST_CALI;
                    next_rank  = '0;
                    next_retry = '0;
                    cali_pulse = 1'b1;
                end
            end
            ST_CALI: begin
                if (cali_done) begin
                    if (!cali_fail) begin
                        if (rank == LAST_RANK) begin
                            next_state = ST_IDLE;
                        end else begin
                            next_rank  = rank + 1'b1;
                            next_retry = '0;
                            cali_pulse = 1'b1;
                        end
                    end else if (retry < RETRY_MAX) begin
                        next_retry = retry + 1'b1;
                        cali_pulse = 1'b1;
                    end else begin
                        next_state = ST_ERROR;
                    end
                end
            end
            ST_IDLE: begin
                if (dfi_phyupd_req) begin
                    next_state = ST_DRAIN;
                    next_tgt   = TGT_PHYUPD;
                end else if (dfi_rdlvl_req || dfi_wrlvl_req) begin
                    next_state = ST_DRAIN;
                    next_tgt   = TGT_CALI;
                end else if (timer_expired) begin
                    next_state = ST_DRAIN;
                    next_tgt   = TGT_CTRLUPD;
                end
            end
            ST_DRAIN: begin
                // A withdrawn PHY request is abandoned before any ack is given.
                if (tgt == TGT_PHYUPD && !dfi_phyupd_req) begin
                    next_state = ST_IDLE;
                end else if (tran_done && r_empty) begin
                    case (tgt)
                        TGT_PHYUPD:  next_state = ST_PHYUPD;
                        TGT_CALI: begin
                            next_state = ST_CALI;
                            next_rank  = '0;
                            next_retry = '0;
                            cali_pulse = 1'b1;
                        end
                        default:     next_state = ST_CTRLUPD;
                    endcase
                end
            end
            // Traffic is already drained, so a pending ctrlupd goes straight out.
            ST_PHYUPD: begin
                if (!dfi_phyupd_req) next_state = timer_expired ? ST_CTRLUPD : ST_IDLE;
            end
            ST_CTRLUPD: begin
                if ((ack_seen || dfi_ctrlupd_ack) && upd_held) next_state = ST_IDLE;
            end
            ST_ERROR:    next_state = ST_ERROR;
            default:     next_state = ST_ERROR;
        endcase
        if (wd_hit) begin
            next_state = ST_ERROR;
            cali_pulse = 1'b0;
        end
    end

`ifdef MAIN_SEQ_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_count;
    logic           wd_watch;

    assign wd_watch = state inside {ST_INIT_DFI, ST_INIT_DDR, ST_CALI, ST_DRAIN, ST_CTRLUPD};
    assign wd_hit   = wd_watch && (wd_count == WDW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge core_clk) begin
        if (!core_arstn || next_state != state) begin
            wd_count <= '0;
        end else if (wd_watch) begin
            wd_count <= wd_count + 1'b1;
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    // Outputs are decoded from next_state so they line up with the state they belong to.
    always_ff @(posedge core_clk) begin
        if (!core_arstn) begin
            state                <= ST_RESET;
            tgt                  <= TGT_PHYUPD;
            rank                 <= '0;
            retry                <= '0;
            ack_seen             <= 1'b0;
            upd_held             <= 1'b0;
            dfi_init_start       <= 1'b0;
            ddr_init_start       <= 1'b0;
            cali_start           <= 1'b0;
            tran_start           <= 1'b0;
            sel                  <= SEL_NONE;
            dfi_dram_clk_disable <= '1;
            dfi_ctrlupd_req      <= 1'b0;
            dfi_phyupd_ack       <= 1'b0;
            err                  <= 1'b0;
        end else begin
            state <= next_state;
            tgt   <= next_tgt;
            rank  <= next_rank;
            retry <= next_retry;
            if (state != ST_CTRLUPD) begin
                ack_seen <= 1'b0;
                upd_held <= 1'b0;
            end else begin
                ack_seen <= ack_seen | dfi_ctrlupd_ack;
                upd_held <= 1'b1;
            end
            dfi_init_start       <= (next_state == ST_INIT_DFI);
            ddr_init_start       <= (next_state == ST_INIT_DDR);
            cali_start           <= cali_pulse;
            tran_start           <= (next_state == ST_IDLE);
            sel                  <= sel_for(next_state);
            dfi_dram_clk_disable <= '0;
            dfi_ctrlupd_req      <= (next_state == ST_CTRLUPD);
            dfi_phyupd_ack       <= (next_state == ST_PHYUPD);
            err                  <= (next_state == ST_ERROR);
        end
    end

    assign cali_rank             = rank;
    assign state_o               = state;
    assign dfi_freq_ratio        = DFI_FREQ_RATIO_1TO4;
    assign dfi_data_byte_disable = '0;

endmodule

// File: tb/tb_main_sequencer.sv
// Self-checking bench for main_sequencer: bring-up, calibration retries, PHY/ctrl updates.
// Define MAIN_SEQ_WATCHDOG_EN to also exercise the watchdog timeout.
module tb_main_sequencer;

    localparam int NUM_RANKS        = 2;
    localparam int NUM_BYTES        = 8;
    localparam int CTRLUPD_INTERVAL = 100;
    localparam int CALI_RETRIES     = 2;
    localparam int TIMEOUT_CYCLES   = 64;
    localparam int RKW              = $clog2(NUM_RANKS) + 1;
    localparam int OW               = 7 + 2 + RKW + 2 + NUM_RANKS + NUM_BYTES + 4;
    localparam logic [OW-1:0] RESET_VEC =
        {7'b0, 2'b00, {RKW{1'b0}}, 2'b11, {NUM_RANKS{1'b1}}, {NUM_BYTES{1'b0}}, 4'd0};
    // Idle entry to ctrlupd_req: INTERVAL counting cycles, one decision cycle, one drain cycle.
    localparam int CTRLUPD_LATENCY  = CTRLUPD_INTERVAL + 2;

    logic core_clk = 1'b0, core_arstn = 1'b0, r_empty = 1'b1, ddr_init_done = 1'b0;
    logic cali_done = 1'b0, cali_fail = 1'b0, tran_done = 1'b1, dfi_init_complete = 1'b0;
    logic dfi_ctrlupd_ack = 1'b0, dfi_phyupd_req = 1'b0, dfi_rdlvl_req = 1'b0, dfi_wrlvl_req = 1'b0;
    logic ddr_init_start, cali_start, tran_start, dfi_init_start, dfi_ctrlupd_req, dfi_phyupd_ack, err;
    logic [RKW-1:0]       cali_rank;
    logic [1:0]           sel, dfi_freq_ratio;
    logic [NUM_BYTES-1:0] dfi_data_byte_disable;
    logic [NUM_RANKS-1:0] dfi_dram_clk_disable;
    logic [3:0]           state_o;

    int vectors = 0;
    int miscompares = 0;

    main_sequencer #(
        .NUM_RANKS(NUM_RANKS), .NUM_BYTES(NUM_BYTES), .CTRLUPD_INTERVAL(CTRLUPD_INTERVAL),
        .CALI_RETRIES(CALI_RETRIES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .core_clk(core_clk), .core_arstn(core_arstn), .r_empty(r_empty),
        .ddr_init_start(ddr_init_start), .ddr_init_done(ddr_init_done),
        .cali_start(cali_start), .cali_rank(cali_rank), .cali_done(cali_done), .cali_fail(cali_fail),
        .tran_start(tran_start), .tran_done(tran_done), .sel(sel),
        .dfi_init_start(dfi_init_start), .dfi_init_complete(dfi_init_complete),
        .dfi_freq_ratio(dfi_freq_ratio), .dfi_data_byte_disable(dfi_data_byte_disable),
        .dfi_dram_clk_disable(dfi_dram_clk_disable),
        .dfi_ctrlupd_req(dfi_ctrlupd_req), .dfi_ctrlupd_ack(dfi_ctrlupd_ack),
        .dfi_phyupd_req(dfi_phyupd_req), .dfi_phyupd_ack(dfi_phyupd_ack),
        .dfi_rdlvl_req(dfi_rdlvl_req), .dfi_wrlvl_req(dfi_wrlvl_req),
        .err(err), .state_o(state_o)
    );

    always #5 core_clk = ~core_clk;

    task automatic step;
        @(posedge core_clk);
        #1;
    endtask

    task automatic apply_reset;
        core_arstn = 1'b0;
        {ddr_init_done, cali_done, cali_fail, dfi_init_complete} = '0;
        {dfi_ctrlupd_ack, dfi_phyupd_req, dfi_rdlvl_req, dfi_wrlvl_req} = '0;
        r_empty = 1'b1;
        tran_done = 1'b1;
        step;
        step;
    endtask

    // Reset, DFI/DRAM init, then calibration with f0/f1 failures on rank 0/1.
    // Ends on the cycle the FSM lands in IDLE or ERROR.
    task automatic bring_up(input int f0, input int f1, output bit expect_err);
        int fails[NUM_RANKS];
        int exp_rank[$];
        bit outcome[$];
        int pulses, n, cyc;
        fails[0] = f0;
        fails[1] = f1;
        expect_err = 1'b0;
        for (int r = 0; r < NUM_RANKS && !expect_err; r++) begin
            for (int a = 0; a <= fails[r]; a++) begin
                exp_rank.push_back(r);
                outcome.push_back(a < fails[r]);
                if (a == CALI_RETRIES && a < fails[r]) begin
                    expect_err = 1'b1;
                    break;
                end
            end
        end

        apply_reset;
        core_arstn = 1'b1;
        step;
        cyc = 1;
        vectors++;
        if ({dfi_init_start, sel, dfi_dram_clk_disable} !== {1'b1, 2'b00, {NUM_RANKS{1'b0}}}) begin
            miscompares++;
            $display("[TB] FAIL init_dfi: got start=%b sel=%b clkdis=%b, want 1 00 0",
                     dfi_init_start, sel, dfi_dram_clk_disable);
        end
        while (cyc < 10) begin step; cyc++; end
        dfi_init_complete = 1'b1;
        step; cyc++;
        dfi_init_complete = 1'b0;
        vectors++;
        if ({ddr_init_start, dfi_init_start, sel} !== {1'b1, 1'b0, 2'b01}) begin
            miscompares++;
            $display("[TB] FAIL init_ddr: got ddr_start=%b dfi_start=%b sel=%b, want 1 0 01",
                     ddr_init_start, dfi_init_start, sel);
        end
        while (cyc < 50) begin step; cyc++; end
        ddr_init_done = 1'b1;
        step;
        ddr_init_done = 1'b0;

        pulses = 0;
        for (int i = 0; i < exp_rank.size(); i++) begin
            n = 0;
            while (cali_start !== 1'b1 && n < 20) begin step; n++; end
            vectors++;
            if (cali_start !== 1'b1 || sel !== 2'b10 || cali_rank !== RKW'(exp_rank[i])) begin
                miscompares++;
                $display("[TB] FAIL cali_pulse[%0d]: got start=%b sel=%b rank=%0d, want 1 10 %0d",
                         i, cali_start, sel, cali_rank, exp_rank[i]);
            end
            pulses++;
            repeat ($urandom_range(1, 3)) begin
                step;
                if (cali_start === 1'b1) pulses++;
            end
            cali_done = 1'b1;
            cali_fail = outcome[i];
            step;
            cali_done = 1'b0;
            cali_fail = 1'b0;
        end
        vectors++;
        if (pulses != exp_rank.size()) begin
            miscompares++;
            $display("[TB] FAIL cali_count: got %0d pulses, want %0d", pulses, exp_rank.size());
        end
        vectors++;
        if (expect_err) begin
            if ({err, sel, tran_start, cali_start} !== {1'b1, 2'b00, 1'b0, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL cali_error: got err=%b sel=%b tran=%b start=%b, want 1 00 0 0",
                         err, sel, tran_start, cali_start);
            end
        end else if ({err, sel, tran_start, cali_start} !== {1'b0, 2'b11, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL cali_idle: got err=%b sel=%b tran=%b start=%b, want 0 11 1 0",
                     err, sel, tran_start, cali_start);
        end
    endtask

    task automatic test_reset;
        logic [OW-1:0] obs;
        apply_reset;
        obs = {dfi_init_start, ddr_init_start, cali_start, tran_start, dfi_ctrlupd_req, dfi_phyupd_ack,
               err, sel, cali_rank, dfi_freq_ratio, dfi_dram_clk_disable, dfi_data_byte_disable, state_o};
        vectors++;
        if (obs !== RESET_VEC) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got %h, want %h", obs, RESET_VEC);
        end
    endtask

    task automatic test_calibration;
        bit e;
        bring_up(0, 0, e);
        bring_up(2, 0, e);
        bring_up(3, 0, e);
        bring_up(0, 3, e);
        repeat (4) bring_up(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), e);
    endtask

    task automatic test_phyupd;
        bit e, ack_ever;
        bring_up(0, 0, e);
        tran_done = 1'b0;
        dfi_phyupd_req = 1'b1;
        repeat (5) begin
            step;
            vectors++;
            if ({dfi_phyupd_ack, tran_start, sel} !== {1'b0, 1'b0, 2'b11}) begin
                miscompares++;
                $display("[TB] FAIL phyupd_drain: got ack=%b tran=%b sel=%b, want 0 0 11",
                         dfi_phyupd_ack, tran_start, sel);
            end
        end
        tran_done = 1'b1;
        step;
        repeat ($urandom_range(1, 4)) begin
            vectors++;
            if ({dfi_phyupd_ack, sel, tran_start} !== {1'b1, 2'b00, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL phyupd_ack: got ack=%b sel=%b tran=%b, want 1 00 0",
                         dfi_phyupd_ack, sel, tran_start);
            end
            step;
        end
        dfi_phyupd_req = 1'b0;
        step;
        vectors++;
        if ({dfi_phyupd_ack, tran_start, sel} !== {1'b0, 1'b1, 2'b11}) begin
            miscompares++;
            $display("[TB] FAIL phyupd_exit: got ack=%b tran=%b sel=%b, want 0 1 11",
                     dfi_phyupd_ack, tran_start, sel);
        end
        // Request withdrawn while traffic is still draining.
        ack_ever = 1'b0;
        tran_done = 1'b0;
        dfi_phyupd_req = 1'b1;
        repeat (2) begin step; ack_ever |= dfi_phyupd_ack; end
        dfi_phyupd_req = 1'b0;
        step;
        ack_ever |= dfi_phyupd_ack;
        tran_done = 1'b1;
        vectors++;
        if ({ack_ever, tran_start} !== {1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL phyupd_withdraw: got ack_seen=%b tran=%b, want 0 1", ack_ever, tran_start);
        end
    endtask

    task automatic test_ctrlupd;
        bit e;
        int k;
        bring_up(0, 0, e);
        for (int round = 0; round < 2; round++) begin
            k = 0;
            while (dfi_ctrlupd_req !== 1'b1 && k < 3 * CTRLUPD_INTERVAL) begin step; k++; end
            vectors++;
            if (k != CTRLUPD_LATENCY || sel !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL ctrlupd_interval[%0d]: got req after %0d cycles sel=%b, want %0d 00",
                         round, k, sel, CTRLUPD_LATENCY);
            end
            if (round == 0) begin
                step;
                step;
                vectors++;
                if (dfi_ctrlupd_req !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL ctrlupd_hold: got req=%b on cycle 3, want 1", dfi_ctrlupd_req);
                end
                dfi_ctrlupd_ack = 1'b1;
                step;
                dfi_ctrlupd_ack = 1'b0;
            end else begin
                // Early ack must not cut the request below two cycles.
                dfi_ctrlupd_ack = 1'b1;
                step;
                dfi_ctrlupd_ack = 1'b0;
                vectors++;
                if (dfi_ctrlupd_req !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL ctrlupd_min_hold: got req=%b on cycle 2, want 1", dfi_ctrlupd_req);
                end
                step;
            end
            vectors++;
            if ({dfi_ctrlupd_req, tran_start} !== {1'b0, 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL ctrlupd_exit[%0d]: got req=%b tran=%b, want 0 1",
                         round, dfi_ctrlupd_req, tran_start);
            end
        end
    endtask

    task automatic test_simultaneous;
        bit e, tran_seen;
        bring_up(0, 0, e);
        repeat (CTRLUPD_INTERVAL) step;
        dfi_phyupd_req = 1'b1;
        tran_seen = 1'b0;
        step;
        step;
        vectors++;
        if ({dfi_phyupd_ack, dfi_ctrlupd_req} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL simul_phy_first: got ack=%b ctrlreq=%b, want 1 0",
                     dfi_phyupd_ack, dfi_ctrlupd_req);
        end
        repeat (2) begin step; tran_seen |= tran_start; end
        dfi_phyupd_req = 1'b0;
        step;
        tran_seen |= tran_start;
        vectors++;
        if ({dfi_ctrlupd_req, dfi_phyupd_ack, tran_seen} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL simul_ctrl_next: got ctrlreq=%b ack=%b tran_seen=%b, want 1 0 0",
                     dfi_ctrlupd_req, dfi_phyupd_ack, tran_seen);
        end
        dfi_ctrlupd_ack = 1'b1;
        step;
        step;
        dfi_ctrlupd_ack = 1'b0;
        vectors++;
        if ({dfi_ctrlupd_req, tran_start} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL simul_exit: got ctrlreq=%b tran=%b, want 0 1", dfi_ctrlupd_req, tran_start);
        end
    endtask

    task automatic test_recal;
        bit e;
        bring_up(0, 0, e);
        if ($urandom_range(0, 1) == 0) dfi_rdlvl_req = 1'b1;
        else dfi_wrlvl_req = 1'b1;
        step;
        dfi_rdlvl_req = 1'b0;
        dfi_wrlvl_req = 1'b0;
        step;
        vectors++;
        if ({cali_start, cali_rank, sel} !== {1'b1, {RKW{1'b0}}, 2'b10}) begin
            miscompares++;
            $display("[TB] FAIL recal_start: got start=%b rank=%0d sel=%b, want 1 0 10",
                     cali_start, cali_rank, sel);
        end
        cali_done = 1'b1;
        step;
        vectors++;
        if ({cali_start, cali_rank} !== {1'b1, RKW'(1)}) begin
            miscompares++;
            $display("[TB] FAIL recal_rank1: got start=%b rank=%0d, want 1 1", cali_start, cali_rank);
        end
        step;
        cali_done = 1'b0;
        vectors++;
        if ({tran_start, sel} !== {1'b1, 2'b11}) begin
            miscompares++;
            $display("[TB] FAIL recal_idle: got tran=%b sel=%b, want 1 11", tran_start, sel);
        end
    endtask

    task automatic test_reset_mid_cali;
        logic [OW-1:0] obs;
        apply_reset;
        core_arstn = 1'b1;
        step;
        dfi_init_complete = 1'b1;
        step;
        dfi_init_complete = 1'b0;
        ddr_init_done = 1'b1;
        step;
        ddr_init_done = 1'b0;
        step;
        core_arstn = 1'b0;
        step;
        obs = {dfi_init_start, ddr_init_start, cali_start, tran_start, dfi_ctrlupd_req, dfi_phyupd_ack,
               err, sel, cali_rank, dfi_freq_ratio, dfi_dram_clk_disable, dfi_data_byte_disable, state_o};
        vectors++;
        if (obs !== RESET_VEC) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_cali: got %h, want %h", obs, RESET_VEC);
        end
    endtask

`ifdef MAIN_SEQ_WATCHDOG_EN
    task automatic test_watchdog;
        apply_reset;
        core_arstn = 1'b1;
        step;
        dfi_init_complete = 1'b1;
        step;
        dfi_init_complete = 1'b0;
        repeat (TIMEOUT_CYCLES - 1) step;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL watchdog_early: got err=%b at cycle %0d, want 0", err, TIMEOUT_CYCLES - 1);
        end
        step;
        vectors++;
        if ({err, sel} !== {1'b1, 2'b00}) begin
            miscompares++;
            $display("[TB] FAIL watchdog_fire: got err=%b sel=%b, want 1 00", err, sel);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_calibration;
        test_phyupd;
        test_ctrlupd;
        test_simultaneous;
        test_recal;
        test_reset_mid_cali;
`ifdef MAIN_SEQ_WATCHDOG_EN
        test_watchdog;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
